// File: rtl/step_dir_decoder.sv
// Step/direction input decoder: synchronizes, qualifies and counts step pulses, tracks motion.
// Optional period measurement enabled by defining STEP_DIR_DECODER_PERIOD_EN.
module step_dir_decoder #(
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_HIGH     = 2,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic        clear,
    output logic [31:0] position,
    output logic        step_strobe,
    output logic        direction,
    output logic        moving,
    output logic        glitch_err,
    output logic [31:0] period
);

    localparam logic [7:0]  MIN_HIGH_M1 = 8'(MIN_HIGH - 1);
    localparam logic [31:0] IDLE_LIM    = 32'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {LOW, QUAL, HIGH} state_t;

    state_t                 state;
    logic [7:0]             qual_cnt;
    logic [SYNC_STAGES-1:0] step_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   armed;
    logic                   step_s;
    logic                   dir_s;
    logic                   accept;
    logic                   moving_fall;
    logic [31:0]            idle_cnt;
    logic [31:0]            delta;
    logic [31:0]            pos_base;

    assign step_s = step_sync[SYNC_STAGES-1];
    assign dir_s  = dir_sync[SYNC_STAGES-1];

    // fill tracks when step_s carries a real sample; armed waits for a low level
    // so a step_in already high at reset release is never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_sync <= '0;
            dir_sync  <= '0;
            fill      <= '0;
            armed     <= 1'b0;
        end else begin
            step_sync <= {step_sync[SYNC_STAGES-2:0], step_in};
            dir_sync  <= {dir_sync[SYNC_STAGES-2:0], dir_in};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            if (fill[SYNC_STAGES-1] && !step_s)
                armed <= 1'b1;
        end
    end

    always_comb begin
        accept = 1'b0;
        case (state)
            LOW:     accept = armed && step_s && (MIN_HIGH == 1);
            QUAL:    accept = step_s && (qual_cnt == MIN_HIGH_M1);
            default: accept = 1'b0;
        endcase
    end

    always_comb begin
        delta       = dir_s ? '1 : 32'd1;
        pos_base    = clear ? '0 : position;
        moving_fall = moving && !accept && (idle_cnt + 32'd1 == IDLE_LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOW;
            qual_cnt    <= '0;
            position    <= '0;
            step_strobe <= 1'b0;
            direction   <= 1'b0;
            glitch_err  <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            if (clear) begin
                position   <= '0;
                glitch_err <= 1'b0;
            end
            if (accept) begin
                step_strobe <= 1'b1;
                direction   <= dir_s;
                position    <= pos_base + delta;
            end
            case (state)
                LOW: begin
                    if (armed && step_s) begin
                        qual_cnt <= 8'd1;
                        state    <= accept ? HIGH : QUAL;
                    end
                end
                QUAL: begin
                    if (!step_s) begin
                        state      <= LOW;
                        glitch_err <= 1'b1;
                    end else if (accept) begin
                        state <= HIGH;
                    end else begin
                        qual_cnt <= qual_cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (!step_s)
                        state <= LOW;
                end
                default: state <= LOW;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            moving   <= 1'b0;
            idle_cnt <= '0;
        end else if (accept) begin
            moving   <= 1'b1;
            idle_cnt <= '0;
        end else if (moving) begin
            idle_cnt <= idle_cnt + 32'd1;
            if (moving_fall)
                moving <= 1'b0;
        end
    end

`ifdef STEP_DIR_DECODER_PERIOD_EN
    logic [31:0] since_cnt;
    logic [31:0] since_inc;
    logic        have_step;

    assign since_inc = (since_cnt == '1) ? since_cnt : since_cnt + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            since_cnt <= '0;
            have_step <= 1'b0;
            period    <= '0;
        end else if (accept) begin
            if (have_step)
                period <= since_inc;
            since_cnt <= '0;
            have_step <= 1'b1;
        end else begin
            since_cnt <= since_inc;
            if (moving_fall)
                period <= '0;
        end
    end
`else
    assign period = '0;
`endif

endmodule

// File: tb/tb_step_dir_decoder.sv
// Scoreboard bench for step_dir_decoder: stimulus queues expected strobes, a monitor checks them.
module tb_step_dir_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_in = 1'b0;
    logic        dir_in = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] position;
    logic        step_strobe;
    logic        direction;
    logic        moving;
    logic        glitch_err;
    logic [31:0] period;

    typedef struct {
        logic [31:0] pos;
        logic        dir;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    step_dir_decoder #(
        .SYNC_STAGES (2),
        .MIN_HIGH    (2),
        .IDLE_TIMEOUT(50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_in    (step_in),
        .dir_in     (dir_in),
        .clear      (clear),
        .position   (position),
        .step_strobe(step_strobe),
        .direction  (direction),
        .moving     (moving),
        .glitch_err (glitch_err),
        .period     (period)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (step_strobe === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe at cycle %0d position=%h", cyc, position);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_position", position, e.pos);
                chk("strobe_direction", {31'b0, direction}, {31'b0, e.dir});
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    // First sampling edge is the next posedge; acceptance three edges later.
    task automatic pulse(input int len, input logic d, input logic [31:0] exp_pos, output int acc);
        @(negedge clk);
        dir_in  = d;
        step_in = 1'b1;
        acc     = cyc + 4;
        q.push_back('{exp_pos, d, acc});
        repeat (len) @(negedge clk);
        step_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int acc;
        int a1;
        int a2;

        repeat (3) @(negedge clk);
        chk("reset_position", position, 32'd0);
        chk("reset_strobe", {31'b0, step_strobe}, 32'd0);
        chk("reset_moving", {31'b0, moving}, 32'd0);
        chk("reset_glitch", {31'b0, glitch_err}, 32'd0);
        chk("reset_period", period, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        pulse(10, 1'b0, 32'd1, acc);
        chk("clean_position", position, 32'd1);
        chk("clean_direction", {31'b0, direction}, 32'd0);
        chk("clean_no_glitch", {31'b0, glitch_err}, 32'd0);

        @(negedge clk);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        repeat (6) @(negedge clk);
        chk("runt_glitch", {31'b0, glitch_err}, 32'd1);
        chk("runt_position", position, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_glitch", {31'b0, glitch_err}, 32'd0);
        chk("clear_position", position, 32'd0);

        for (int i = 1; i <= 5; i++)
            pulse(4, 1'b1, 32'(-i), acc);
        chk("down_position", position, 32'hFFFF_FFFB);
        chk("down_direction", {31'b0, direction}, 32'd1);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 1; i <= 100; i++)
            pulse(3, 1'b0, 32'(i), acc);
        chk("up100_position", position, 32'd100);
        chk("up100_moving", {31'b0, moving}, 32'd1);

        // Clear lands on the acceptance edge.
        @(negedge clk);
        dir_in  = 1'b0;
        step_in = 1'b1;
        acc     = cyc + 4;
        q.push_back('{32'd1, 1'b0, acc});
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        step_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("collide_position", position, 32'd1);

        // Long high with direction flip while in HIGH: one step, old direction.
        @(negedge clk);
        dir_in  = 1'b0;
        step_in = 1'b1;
        acc     = cyc + 4;
        q.push_back('{32'd2, 1'b0, acc});
        repeat (6) @(negedge clk);
        dir_in = 1'b1;
        repeat (20) @(negedge clk);
        step_in = 1'b0;
        dir_in  = 1'b0;
        repeat (4) @(negedge clk);
        chk("longhigh_position", position, 32'd2);
        chk("longhigh_direction", {31'b0, direction}, 32'd0);

        pulse(10, 1'b0, 32'd3, a1);
        while (cyc < a1 - 4 + 39) @(negedge clk);
        pulse(10, 1'b0, 32'd4, a2);
        chk("second_accept_spacing", a2 - a1, 32'd40);
`ifdef STEP_DIR_DECODER_PERIOD_EN
        chk("period_40", period, 32'd40);
`else
        chk("period_tied", period, 32'd0);
`endif
        while (cyc < a2 + 49) @(negedge clk);
        chk("idle_moving_49", {31'b0, moving}, 32'd1);
        @(negedge clk);
        chk("idle_moving_50", {31'b0, moving}, 32'd0);
        chk("idle_period", period, 32'd0);

        // Reset asserted and released with step_in held high.
        @(negedge clk);
        step_in = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_position", position, 32'd0);
        chk("rst2_direction", {31'b0, direction}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        step_in = 1'b0;
        repeat (8) @(negedge clk);
        chk("held_high_position", position, 32'd0);
        chk("held_high_glitch", {31'b0, glitch_err}, 32'd0);
        pulse(10, 1'b0, 32'd1, acc);
        chk("after_rst_position", position, 32'd1);
        chk("after_rst_period", period, 32'd0);

        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_dir_decoder.md
STEP_DIR_DECODER -- requirements
Module: step_dir_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on step_in/dir_in, legal range 2..4.
REQ-002 SHALL have parameter MIN_HIGH, default 2: consecutive synchronized-high cycles that qualify a step pulse, legal range 1..255.
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 1000000: cycles with no accepted step before motion is declared stopped.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port step_in, input, 1: external step pulse, asynchronous to clk.
REQ-007 SHALL have port dir_in, input, 1: external direction, 0 = count up, 1 = count down, asynchronous to clk.
REQ-008 SHALL have port clear, input, 1: synchronous zeroing of position and error.
REQ-009 SHALL have port position, output, 32: two's-complement accumulated step count.
REQ-010 SHALL have port step_strobe, output, 1: one-cycle pulse per accepted step.
REQ-011 SHALL have port direction, output, 1: direction latched at the last accepted step.
REQ-012 SHALL have port moving, output, 1: high while steps arrive within IDLE_TIMEOUT.
REQ-013 SHALL have port glitch_err, output, 1: sticky runt-pulse flag.
REQ-014 SHALL have port period, output, 32: cycles between the last two accepted steps.

Function
REQ-015 SHALL pass step_in and dir_in each through a SYNC_STAGES flop chain; step_s and dir_s denote the final stages.
REQ-016 SHALL implement states LOW, QUAL and HIGH: LOW->QUAL on step_s=1; QUAL->LOW on step_s=0 before qualification; QUAL->HIGH on qualification; HIGH->LOW on step_s=0.
REQ-017 SHALL accept a step on the edge where step_s has been 1 for MIN_HIGH consecutive edges; step_strobe asserts SYNC_STAGES+MIN_HIGH edges after the first edge sampling step_in=1 (4 with defaults).
REQ-018 SHALL, on acceptance, sample dir_s into direction and add +1 (dir_s=0) or -1 (dir_s=1) to position, with position and step_strobe updating on the same edge.
REQ-019 SHALL wrap position modulo 2^32: 0x7FFFFFFF+1 gives 0x80000000, and 0 minus 1 gives 0xFFFFFFFF.
REQ-020 SHALL set glitch_err on the QUAL->LOW transition, leave position unchanged and not pulse step_strobe.
REQ-021 SHALL accept at most one step per pulse; a step_s high of any length in HIGH adds nothing, and a dir_in change during HIGH is ignored.
REQ-022 SHALL, on clear=1, load position with 0 and glitch_err with 0; if a step is accepted on the same edge, position SHALL become +1 or -1 and step_strobe SHALL still pulse.
REQ-023 SHALL set moving=1 on each accepted step, reload an idle counter to 0, and clear moving when the counter reaches IDLE_TIMEOUT.
REQ-024 SHALL keep the FSM state and the synchronizers unaffected by clear.

Reset
REQ-025 SHALL, on rst=1 and independent of clk, force the FSM to LOW, all synchronizer flops to 0, position=0, step_strobe=0, direction=0, moving=0, glitch_err=0, period=0, and all counters to 0.
REQ-026 SHALL NOT count a step_in level already high at reset release until it has been seen low (FSM starts in LOW only after step_s=0).

Configuration
REQ-027 SHALL, with STEP_DIR_DECODER_PERIOD_EN defined, count cycles since the last accepted step (saturating at 0xFFFFFFFF), load that count into period on each accepted step after the first, and zero period when moving falls.
REQ-028 SHALL, without STEP_DIR_DECODER_PERIOD_EN, keep the period port present but tied to 0 and instantiate no period counter.

Verification
REQ-029 SHALL test a single clean pulse: 10-cycle step_in pulse with dir_in=0 from reset -> step_strobe once at edge 4, position=1, direction=0.
REQ-030 SHALL test a runt pulse: 1-cycle step_in pulse -> glitch_err=1, position unchanged, no step_strobe; then clear=1 -> glitch_err=0.
REQ-031 SHALL test direction and wrap: 5 pulses with dir_in=1 from position=0 -> position=0xFFFFFFFB, direction=1.
REQ-032 SHALL test clear colliding with a step: clear asserted on the acceptance edge with dir_in=0 and position=100 -> position=1.
REQ-033 SHALL test idle timeout with IDLE_TIMEOUT=50: one pulse then silence -> moving=1 for 50 cycles after acceptance, then moving=0.
REQ-034 SHALL test period measurement with the macro defined: pulses 40 cycles apart -> period=40 after the second pulse, and period=0 after the timeout.
